// File: rtl/ahb3lite_arbiter.sv
// ahb3lite_arbiter: round-robin arbiter that shares one AHB3-Lite slave port
// among up to four masters. Ownership changes only at burst boundaries, idle
// cycles, ERROR responses, or when an undefined-length INCR owner lets go.
// Address-phase signals follow HMASTER; write data follows the data-phase
// owner HMASTER_D.
module ahb3lite_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [N_MASTERS-1:0]    HBUSREQ,
    input  logic [2*N_MASTERS-1:0]  M_HTRANS,
    input  logic [32*N_MASTERS-1:0] M_HADDR,
    input  logic [N_MASTERS-1:0]    M_HWRITE,
    input  logic [3*N_MASTERS-1:0]  M_HSIZE,
    input  logic [3*N_MASTERS-1:0]  M_HBURST,
    input  logic [32*N_MASTERS-1:0] M_HWDATA,
    input  logic                    HREADY,
    input  logic                    HRESP,
    output logic [N_MASTERS-1:0]    HGRANT,
    output logic [1:0]              HMASTER,
    output logic [1:0]              HMASTER_D,
    output logic [1:0]              S_HTRANS,
    output logic [31:0]             S_HADDR,
    output logic                    S_HWRITE,
    output logic [2:0]              S_HSIZE,
    output logic [2:0]              S_HBURST,
    output logic [31:0]             S_HWDATA
);

    localparam logic [1:0] DEF_IDX   = 2'(DEFAULT_MASTER);
    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;

    typedef enum logic {PARK, BURST} state_t;

    state_t     state;
    logic [4:0] counter;
    logic [4:0] burst_len;
    logic [1:0] last_owner;

    logic       beat_ok;
    logic       is_nonseq;
    logic [4:0] beat_num;
    logic [4:0] cur_len;
    logic       last_beat;
    logic       owner_req;
    logic       arb_point;
    logic [1:0] winner;
    logic       req_found;
    int         rr_idx;

    // Number of beats implied by HBURST; 0 marks undefined-length INCR.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            3'd0:       return 5'd1;
            3'd1:       return 5'd0;
            3'd2, 3'd3: return 5'd4;
            3'd4, 3'd5: return 5'd8;
            default:    return 5'd16;
        endcase
    endfunction

    function automatic logic [N_MASTERS-1:0] one_hot(input logic [1:0] idx);
        logic [N_MASTERS-1:0] v;
        v = '0;
        for (int i = 0; i < N_MASTERS; i++)
            if (idx == 2'(i)) v[i] = 1'b1;
        return v;
    endfunction

    // Address-phase mux follows HMASTER, write-data mux follows HMASTER_D.
    always_comb begin
        S_HTRANS = '0;
        S_HADDR  = '0;
        S_HWRITE = 1'b0;
        S_HSIZE  = '0;
        S_HBURST = '0;
        S_HWDATA = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (HMASTER == 2'(i)) begin
                S_HTRANS = M_HTRANS[2*i +: 2];
                S_HADDR  = M_HADDR[32*i +: 32];
                S_HWRITE = M_HWRITE[i];
                S_HSIZE  = M_HSIZE[3*i +: 3];
                S_HBURST = M_HBURST[3*i +: 3];
            end
            if (HMASTER_D == 2'(i))
                S_HWDATA = M_HWDATA[32*i +: 32];
        end
    end

    // Beat bookkeeping: a NONSEQ restarts the count and supplies the length
    // for the beat it is on, so a SINGLE is its own last beat.
    assign beat_ok   = HREADY && S_HTRANS[1];
    assign is_nonseq = (S_HTRANS == TR_NONSEQ);
    assign beat_num  = is_nonseq ? 5'd1 : counter + 5'd1;
    assign cur_len   = is_nonseq ? burst_beats(S_HBURST) : burst_len;
    assign last_beat = beat_ok && (cur_len != 5'd0) && (beat_num == cur_len);

    // A parked master holds the bus by default rather than by request, so it
    // never blocks arbitration during an undefined-length burst.
    assign owner_req = (|(HBUSREQ & one_hot(HMASTER))) && (state == BURST);
    assign arb_point = HREADY && ((S_HTRANS == TR_IDLE) || last_beat ||
                                  ((cur_len == 5'd0) && !owner_req) || HRESP);

    // Round-robin search starting after the last owner, which is tried last.
    always_comb begin
        winner    = DEF_IDX;
        req_found = 1'b0;
        rr_idx    = 0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            rr_idx = int'(last_owner) + k;
            if (rr_idx >= N_MASTERS) rr_idx = rr_idx - N_MASTERS;
            if (!req_found && (|(HBUSREQ & one_hot(2'(rr_idx))))) begin
                req_found = 1'b1;
                winner    = 2'(rr_idx);
            end
        end
    end

    // Ownership FSM, beat counter and data-phase owner tracking.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= PARK;
            HGRANT     <= one_hot(DEF_IDX);
            HMASTER    <= DEF_IDX;
            HMASTER_D  <= DEF_IDX;
            last_owner <= DEF_IDX;
            counter    <= '0;
            burst_len  <= '0;
        end else begin
            if (HREADY)
                HMASTER_D <= HMASTER;
            if (beat_ok) begin
                counter <= beat_num;
                if (is_nonseq)
                    burst_len <= cur_len;
            end
            if (arb_point) begin
                HGRANT  <= one_hot(winner);
                HMASTER <= winner;
                if (req_found) begin
                    state      <= BURST;
                    last_owner <= winner;
                end else begin
                    state <= PARK;
                end
            end
        end
    end

endmodule
